// File: rtl/jtag_chain_ctrl.sv
// jtag_chain_ctrl: user-DR side of a BSCANE2-style TAP.
// Owns the DR shift register, decodes each updated frame into a read/write
// command and runs a req/ack handshake (with timeout) to one of CHAIN_NUM
// endpoints. Everything runs on TCK; endpoint-side CDC lives elsewhere.
//
// DR frame (shifted LSB first):
//   [DW-1:0]          data
//   [DW+1:DW]         cmd  (00 NOP/clear, 01 WRITE, 10 READ, 11 reserved)
//   [DR_W-1:DW+2]     chain id
// On capture the cmd field carries status instead: bit DW = busy, bit DW+1 = err,
// the data field carries the last read data and the id field the last accepted id.
module jtag_chain_ctrl #(
    parameter int CHAIN_NUM  = 4,
    parameter int CHAIN_ID_W = 2,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sel,
    input  logic                    capture,
    input  logic                    shift,
    input  logic                    update,
    input  logic                    tdi,
    output logic                    tdo,
    output logic [CHAIN_NUM-1:0]    ep_req,
    output logic                    ep_we,
    output logic [DW-1:0]           ep_wdata,
    input  logic [CHAIN_NUM*DW-1:0] ep_rdata,
    input  logic [CHAIN_NUM-1:0]    ep_ack,
    output logic                    busy,
    output logic                    err
);

    localparam int DR_W  = CHAIN_ID_W + 2 + DW;
    localparam int CNT_W = 8;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t                 state_q, state_d;
    logic [DR_W-1:0]        shreg_q, shreg_d;
    logic [CHAIN_NUM-1:0]   ep_req_q, ep_req_d;
    logic                   ep_we_q, ep_we_d;
    logic [DW-1:0]          ep_wdata_q, ep_wdata_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [DW-1:0]          rd_latch_q, rd_latch_d;
    logic [CHAIN_ID_W-1:0]  last_id_q, last_id_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Frame fields as seen by the update decoder
    logic [DW-1:0]          fr_data;
    logic [1:0]             fr_cmd;
    logic [CHAIN_ID_W-1:0]  fr_id;
    logic                   fr_id_ok;

    // TAP strobes after sel gating and capture > shift > update priority
    logic                   do_capture, do_shift, do_update;

    // Ack/read data of the endpoint currently being served
    logic                   ack_sel;
    logic [DW-1:0]          rdata_sel;

    // Error bookkeeping: any set on an edge beats a clear on the same edge
    logic                   err_set, err_clr;
    logic                   cmd_rw, cmd_accept;

    assign fr_data  = shreg_q[DW-1:0];
    assign fr_cmd   = shreg_q[DW+1:DW];
    assign fr_id    = shreg_q[DR_W-1:DW+2];
    assign fr_id_ok = {{(32-CHAIN_ID_W){1'b0}}, fr_id} < 32'(CHAIN_NUM);

    assign do_capture = sel & capture;
    assign do_shift   = sel & shift & ~capture;
    assign do_update  = sel & update & ~capture & ~shift;

    assign tdo      = shreg_q[0];
    assign ep_req   = ep_req_q;
    assign ep_we    = ep_we_q;
    assign ep_wdata = ep_wdata_q;
    assign busy     = busy_q;
    assign err      = err_q;

    // Select ack and read data of last_id; acks from other endpoints never reach the FSM
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < CHAIN_NUM; i++) begin
            if (last_id_q == CHAIN_ID_W'(i)) begin
                ack_sel   = ep_ack[i];
                rdata_sel = ep_rdata[i*DW +: DW];
            end
        end
    end

    // Shift register next state: capture status or shift towards tdo
    always_comb begin
        shreg_d = shreg_q;
        if (do_capture) begin
            shreg_d = {last_id_q, err_q, busy_q, rd_latch_q};
        end else if (do_shift) begin
            shreg_d = {tdi, shreg_q[DR_W-1:1]};
        end
    end

    // Update decode: classify the frame into clear / accepted command / error
    always_comb begin
        err_set    = 1'b0;
        err_clr    = 1'b0;
        cmd_rw     = 1'b0;
        cmd_accept = 1'b0;
        if (do_update) begin
            case (fr_cmd)
                CMD_NOP: err_clr = fr_data[0];
                CMD_WRITE, CMD_READ: cmd_rw = 1'b1;
                default: ;
            endcase
            if (cmd_rw) begin
                // Bad id or a transaction already in flight: drop and flag
                if (!fr_id_ok || state_q != IDLE) begin
                    err_set = 1'b1;
                end else begin
                    cmd_accept = 1'b1;
                end
            end
        end
    end

    // Handshake FSM next state and registered outputs
    always_comb begin
        state_d    = state_q;
        ep_req_d   = ep_req_q;
        ep_we_d    = ep_we_q;
        ep_wdata_d = ep_wdata_q;
        busy_d     = busy_q;
        rd_latch_d = rd_latch_q;
        last_id_d  = last_id_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d   = REQ;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    last_id_d = fr_id;
                    ep_we_d   = (fr_cmd == CMD_WRITE);
                    if (fr_cmd == CMD_WRITE) begin
                        ep_wdata_d = fr_data;
                    end
                    for (int i = 0; i < CHAIN_NUM; i++) begin
                        ep_req_d[i] = (fr_id == CHAIN_ID_W'(i));
                    end
                end
            end
            REQ: begin
                if (ack_sel) begin
                    // Ack wins over a timeout landing on the same edge
                    if (!ep_we_q) begin
                        rd_latch_d = rdata_sel;
                    end
                    ep_req_d = '0;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ep_req_d = '0;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                ep_req_d = '0;
                busy_d   = 1'b0;
            end
        endcase

        if (err_set || (state_q == REQ && !ack_sel && cnt_q == CNT_W'(TIMEOUT - 1))) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // State registers; reset drops any outstanding request immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            ep_req_q   <= '0;
            ep_we_q    <= 1'b0;
            ep_wdata_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_latch_q <= '0;
            last_id_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            ep_req_q   <= ep_req_d;
            ep_we_q    <= ep_we_d;
            ep_wdata_q <= ep_wdata_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rd_latch_q <= rd_latch_d;
            last_id_q  <= last_id_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
